niosii_system_sysid_ctrl: RTL
=============================

# niosII_system_sysid_ctrl

Boot-time system-ID verification controller. Sequences the two reads of the Qsys system-ID slave: word 0 is the ID and word 1 is the build timestamp. It captures both words and compares them against build-time expected values, then reports pass/fail on sideband outputs and through a small Avalon-MM CSR slave. Software polls or restarts the check through this slave. Sits between the system-ID slave and the Nios II data master.

## Interface
Parameters:
- EXPECTED_ID, 32'd0: value that word 0 must return.
- EXPECTED_TIMESTAMP, 32'd1486414059: value that word 1 must return.
- READ_LATENCY, 0: cycles from the read-issue cycle to the readdata capture cycle; legal range 0..3.
- AUTO_START, 1: when 1, the check launches automatically on the first clock after reset release.

Ports:
- clock, in, 1: single clock; all state is clocked on its rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- sysid_address, out, 1: word select to the system-ID slave.
- sysid_read, out, 1: read strobe to the system-ID slave.
- sysid_readdata, in, 32: data returned by the system-ID slave.
- csr_address, in, 2: CSR word select.
- csr_read, in, 1: CSR read strobe.
- csr_write, in, 1: CSR write strobe.
- csr_writedata, in, 32: CSR write data.
- csr_readdata, out, 32: CSR read data; registered, 1-cycle read latency.
- check_done, out, 1: high while the result is valid.
- check_pass, out, 1: high when both captured words matched; meaningful only while check_done is high.

## Operation
States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.

- **IDLE**
  - With AUTO_START=1: go to RD_ID on the first clock after reset deassertion.
  - With AUTO_START=0: stay until a restart command is written.
- **RD_ID**
  - sysid_read=1, sysid_address=0 for exactly one cycle.
  - If READ_LATENCY=0, capture id_cap from sysid_readdata this cycle and go to RD_TS.
  - Otherwise go to WAIT_ID.
- **WAIT_ID**
  - Latency counter runs; sysid_read=0 and sysid_address is held at 0.
  - On count == READ_LATENCY: capture id_cap and go to RD_TS.
- **RD_TS / WAIT_TS**
  - Same as RD_ID / WAIT_ID, with sysid_address=1 and capture into ts_cap.
  - After the capture, go to DONE.
- **DONE**
  - On entry, register pass = (id_cap == EXPECTED_ID) && (ts_cap == EXPECTED_TIMESTAMP).
  - Set check_done=1.
  - Stay in DONE until a restart command is written.

CSR map (word addresses):
- 0 STATUS (read-only): bit0 done, bit1 id_ok, bit2 ts_ok, bit3 busy (state not IDLE/DONE). Bits 31:4 read 0.
- 1 ID_CAP: captured word 0; reads 0 until captured.
- 2 TS_CAP: captured word 1; reads 0 until captured.
- 3 CONTROL:
  - Write with bit0=1 = restart. Accepted only in IDLE or DONE.
  - On acceptance: done, pass, id_ok, ts_ok and both capture registers clear; state goes to RD_ID next cycle.
  - Restart written while busy is ignored.
  - Reads return 0.

Boundary rules:
- Simultaneous csr_read and csr_write in one cycle: both are serviced. Read data reflects the pre-write state.
- Reset mid-sequence clears everything, returns to IDLE, then obeys AUTO_START.
- sysid_address holds its last value outside the read windows. Its reset value is 0.

## Timing
- Reset values: sysid_read=0, sysid_address=0, csr_readdata=0, check_done=0, check_pass=0, all captures 0.
- Check duration: the ID read takes READ_LATENCY+1 cycles and the TS read takes READ_LATENCY+1 cycles. check_done rises 1 cycle after the TS capture, i.e. 2·(READ_LATENCY+1)+1 cycles after entering RD_ID.
- With READ_LATENCY=0 and AUTO_START=1: RD_ID at cycle 1 after reset release, RD_TS at cycle 2, check_done=1 from cycle 3.
- CSR: csr_readdata is valid on the clock after csr_read. A write takes effect on the clock edge on which it is sampled.

## Structure
- Package niosII_system_sysid_ctrl_pkg holds:
  - the state enum;
  - CSR word offsets;
  - STATUS bit positions;
  - the CONTROL restart bit position.
- One sub-module, niosII_system_sysid_ctrl_csr, holds the CSR decode and the registered readdata mux. The FSM, latency counter and capture registers live in the top module.

## Test plan
- **Auto-check pass.** AUTO_START=1, READ_LATENCY=0, slave model returns 0 / 1486414059. Expect check_done=1 at cycle 3 and check_pass=1; STATUS reads 0x7; TS_CAP reads 1486414059.
- **Timestamp mismatch.** Slave returns 1486414058 at word 1. Expect check_pass=0 and STATUS reads 0x3 (done, id_ok).
- **Added read latency.** READ_LATENCY=2. Expect capture exactly 2 cycles after each read strobe, sysid_address held through each wait, and check_done at cycle 7.
- **Restart handling.** With AUTO_START=0 the FSM stays in IDLE and STATUS reads 0. Write CONTROL=1: expect busy=1 the next cycle, then done. Write CONTROL=1 again while busy: expect it ignored and no extra sysid_read pulse.
- **Reset mid-sequence.** Assert reset_n=0 during WAIT_TS. Expect all outputs and captures to go to 0 immediately. After release, expect a full re-check.

Source files
------------

// File: rtl/niosii_system_sysid_ctrl_pkg.sv
// Shared types and constants for the system-ID verification controller.
package niosii_system_sysid_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_WAIT_ID,
    ST_RD_TS,
    ST_WAIT_TS,
    ST_DONE
  } state_t;

  localparam logic [1:0] CSR_STATUS  = 2'd0;
  localparam logic [1:0] CSR_ID_CAP  = 2'd1;
  localparam logic [1:0] CSR_TS_CAP  = 2'd2;
  localparam logic [1:0] CSR_CONTROL = 2'd3;

  localparam int unsigned STATUS_DONE_BIT  = 0;
  localparam int unsigned STATUS_ID_OK_BIT = 1;
  localparam int unsigned STATUS_TS_OK_BIT = 2;
  localparam int unsigned STATUS_BUSY_BIT  = 3;

  localparam int unsigned CTRL_RESTART_BIT = 0;

  function automatic logic [31:0] pack_status(input logic done, input logic id_ok,
                                              input logic ts_ok, input logic busy);
    logic [31:0] v;
    v = '0;
    v[STATUS_DONE_BIT]  = done;
    v[STATUS_ID_OK_BIT] = id_ok;
    v[STATUS_TS_OK_BIT] = ts_ok;
    v[STATUS_BUSY_BIT]  = busy;
    return v;
  endfunction

endpackage

// File: rtl/niosii_system_sysid_ctrl_csr.sv
// CSR decode and registered readdata mux for the system-ID controller.
module niosii_system_sysid_ctrl_csr
  import niosii_system_sysid_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  i_csr_address,
  input  logic        i_csr_read,
  input  logic        i_csr_write,
  input  logic [31:0] i_csr_writedata,
  input  logic        i_done,
  input  logic        i_id_ok,
  input  logic        i_ts_ok,
  input  logic        i_busy,
  input  logic [31:0] i_id_cap,
  input  logic [31:0] i_ts_cap,
  output logic [31:0] o_csr_readdata,
  output logic        o_restart_req
);

  logic [31:0] r_readdata;
  logic [31:0] w_rd_mux;
  logic        w_unused_wdata;

  // Only the restart bit of CONTROL carries meaning.
  assign w_unused_wdata = &{1'b0, i_csr_writedata[31:1]};

  always_comb begin
    w_rd_mux = '0;
    case (i_csr_address)
      CSR_STATUS:  w_rd_mux = pack_status(i_done, i_id_ok, i_ts_ok, i_busy);
      CSR_ID_CAP:  w_rd_mux = i_id_cap;
      CSR_TS_CAP:  w_rd_mux = i_ts_cap;
      CSR_CONTROL: w_rd_mux = '0;
      default:     w_rd_mux = '0;
    endcase
  end

  // The mux sees pre-edge state, so a read paired with a write returns pre-write data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else if (i_csr_read) begin
      r_readdata <= w_rd_mux;
    end
  end

  assign o_csr_readdata = r_readdata;
  assign o_restart_req  = i_csr_write && (i_csr_address == CSR_CONTROL)
                          && i_csr_writedata[CTRL_RESTART_BIT];

endmodule

// File: rtl/niosii_system_sysid_ctrl.sv
// Boot-time system-ID check: reads ID and timestamp words, compares, reports pass/fail.
module niosii_system_sysid_ctrl
  import niosii_system_sysid_ctrl_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1486414059,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned AUTO_START         = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  input  logic [1:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic        check_done,
  output logic        check_pass
);

  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_lat_cnt;
  logic [31:0] r_id_cap;
  logic [31:0] r_ts_cap;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_done;
  logic        r_pass;
  logic        r_sysid_address;

  logic        w_restart_req;
  logic        w_restart;
  logic        w_cap_id;
  logic        w_cap_ts;
  logic        w_sysid_read;
  logic        w_busy;
  logic        w_id_match;
  logic        w_ts_match;

  assign w_busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_id_match = (sysid_readdata == EXPECTED_ID);
  assign w_ts_match = (sysid_readdata == EXPECTED_TIMESTAMP);

  always_comb begin
    w_state_next = r_state;
    w_restart    = 1'b0;
    w_cap_id     = 1'b0;
    w_cap_ts     = 1'b0;
    w_sysid_read = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // IDLE is only re-entered through reset, so auto-start needs no one-shot flag.
        if (w_restart_req) begin
          w_restart    = 1'b1;
          w_state_next = ST_RD_ID;
        end else if (AUTO_START != 0) begin
          w_state_next = ST_RD_ID;
        end
      end
      ST_RD_ID: begin
        w_sysid_read = 1'b1;
        if (LAT == 2'd0) begin
          w_cap_id     = 1'b1;
          w_state_next = ST_RD_TS;
        end else begin
          w_state_next = ST_WAIT_ID;
        end
      end
      ST_WAIT_ID: begin
        if (r_lat_cnt == LAT) begin
          w_cap_id     = 1'b1;
          w_state_next = ST_RD_TS;
        end
      end
      ST_RD_TS: begin
        w_sysid_read = 1'b1;
        if (LAT == 2'd0) begin
          w_cap_ts     = 1'b1;
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_WAIT_TS;
        end
      end
      ST_WAIT_TS: begin
        if (r_lat_cnt == LAT) begin
          w_cap_ts     = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_restart_req) begin
          w_restart    = 1'b1;
          w_state_next = ST_RD_ID;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Counter is primed to 1 in the strobe cycle so the capture lands READ_LATENCY cycles later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lat_cnt <= '0;
    end else if ((r_state == ST_RD_ID) || (r_state == ST_RD_TS)) begin
      r_lat_cnt <= 2'd1;
    end else if ((r_state == ST_WAIT_ID) || (r_state == ST_WAIT_TS)) begin
      r_lat_cnt <= r_lat_cnt + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sysid_address <= 1'b0;
    end else if (w_state_next == ST_RD_ID) begin
      r_sysid_address <= 1'b0;
    end else if (w_state_next == ST_RD_TS) begin
      r_sysid_address <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_id_cap <= '0;
      r_ts_cap <= '0;
      r_id_ok  <= 1'b0;
      r_ts_ok  <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else if (w_restart) begin
      r_id_cap <= '0;
      r_ts_cap <= '0;
      r_id_ok  <= 1'b0;
      r_ts_ok  <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      if (w_cap_id) begin
        r_id_cap <= sysid_readdata;
        r_id_ok  <= w_id_match;
      end
      if (w_cap_ts) begin
        r_ts_cap <= sysid_readdata;
        r_ts_ok  <= w_ts_match;
        r_done   <= 1'b1;
        r_pass   <= r_id_ok && w_ts_match;
      end
    end
  end

  niosii_system_sysid_ctrl_csr u_csr (
    .clock           (clock),
    .reset_n         (reset_n),
    .i_csr_address   (csr_address),
    .i_csr_read      (csr_read),
    .i_csr_write     (csr_write),
    .i_csr_writedata (csr_writedata),
    .i_done          (r_done),
    .i_id_ok         (r_id_ok),
    .i_ts_ok         (r_ts_ok),
    .i_busy          (w_busy),
    .i_id_cap        (r_id_cap),
    .i_ts_cap        (r_ts_cap),
    .o_csr_readdata  (csr_readdata),
    .o_restart_req   (w_restart_req)
  );

  assign sysid_read    = w_sysid_read;
  assign sysid_address = r_sysid_address;
  assign check_done    = r_done;
  assign check_pass    = r_pass;

endmodule
